// File: rtl/rr_grant_arbiter.sv
// rtl/rr_grant_arbiter.sv - registered round-robin arbiter with one-hot grant held until release
// Optional hold-timeout revocation is built when RR_ARB_TIMEOUT_EN is defined.
module rr_grant_arbiter #(
  parameter int N        = 4,
  parameter int IDW      = 2,
  parameter int MAX_HOLD = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  output logic           any_req,
  output logic [N-1:0]   gnt,
  output logic           gnt_valid,
  output logic [IDW-1:0] gnt_id,
  output logic           timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  state_t         state;
  logic [IDW-1:0] ptr;
  logic           found;
  logic [IDW-1:0] win;
  logic [IDW:0]   idx;
  logic           expire;
  logic           keep;

  assign any_req = |req;

  // Search ptr+1 .. ptr (mod N); the previous winner is visited last.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      idx = {1'b0, ptr} + (IDW + 1)'(k);
      if (idx >= (IDW + 1)'(N)) idx = idx - (IDW + 1)'(N);
      if (!found && req[idx[IDW-1:0]]) begin
        found = 1'b1;
        win   = idx[IDW-1:0];
      end
    end
  end

  assign keep = (state == GRANT) && req[gnt_id] && !expire;

`ifdef RR_ARB_TIMEOUT_EN
  logic [7:0] hold_cnt;
  logic       timeout_q;

  assign expire  = (hold_cnt == 8'(MAX_HOLD));
  assign timeout = timeout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= (state == GRANT) && req[gnt_id] && expire;
      if (keep)
        hold_cnt <= hold_cnt + 8'd1;
      else if (found)
        hold_cnt <= '0;
    end
  end
`else
  // Grants never expire in this build; MAX_HOLD is always at least 1.
  assign expire  = (MAX_HOLD == 0);
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= IDW'(N - 1);
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_id    <= '0;
    end else if (keep) begin
      state <= GRANT;
    end else if (found) begin
      state     <= GRANT;
      ptr       <= win;
      gnt       <= ONE << win;
      gnt_valid <= 1'b1;
      gnt_id    <= win;
    end else begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// tb/tb_rr_grant_arbiter.sv - directed and randomized checks of rr_grant_arbiter against a reference model
module tb_rr_grant_arbiter;

  localparam int N   = 4;
  localparam int IDW = 2;
`ifdef RR_ARB_TIMEOUT_EN
  localparam bit TO_EN   = 1'b1;
  localparam int TB_HOLD = 4;
`else
  localparam bit TO_EN   = 1'b0;
  localparam int TB_HOLD = 16;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic           any_req;
  logic [N-1:0]   gnt;
  logic           gnt_valid;
  logic [IDW-1:0] gnt_id;
  logic           timeout;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: current holder (-1 when idle), last winner, id, hold age
  int m_holder = -1;
  int m_last   = N - 1;
  int m_id     = 0;
  int m_cnt    = 0;
  bit m_to     = 1'b0;

  rr_grant_arbiter #(.N(N), .IDW(IDW), .MAX_HOLD(TB_HOLD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .any_req   (any_req),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] exp_gnt();
    logic [N-1:0] v;
    v = '0;
    if (m_holder >= 0) v[m_holder] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    m_holder = -1;
    m_last   = N - 1;
    m_id     = 0;
    m_cnt    = 0;
    m_to     = 1'b0;
  endtask

  task automatic model_edge(input logic [N-1:0] r);
    int w;
    m_to = 1'b0;
    if (m_holder >= 0 && r[m_holder] && !(TO_EN && m_cnt == TB_HOLD)) begin
      m_cnt++;
    end else begin
      if (m_holder >= 0 && r[m_holder]) m_to = 1'b1;
      w = -1;
      for (int k = 1; k <= N; k++)
        if (w < 0 && r[(m_last + k) % N]) w = (m_last + k) % N;
      m_holder = w;
      if (w >= 0) begin
        m_last = w;
        m_id   = w;
        m_cnt  = 0;
      end
    end
  endtask

  // Entered and left at a falling edge.
  task automatic step(input logic [N-1:0] r);
    req = r;
    #1;
    check("any_req", any_req, (r != 0));
    @(posedge clk);
    model_edge(r);
    #1;
    check("gnt", gnt, exp_gnt());
    check("gnt_valid", gnt_valid, (m_holder >= 0));
    check("gnt_id", gnt_id, m_id);
    check("timeout", timeout, m_to);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    repeat (2) @(negedge clk);
    check("rst_gnt", gnt, 0);
    check("rst_gnt_valid", gnt_valid, 0);
    check("rst_gnt_id", gnt_id, 0);
    check("rst_timeout", timeout, 0);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [N-1:0] rv;
    int order[$];
    int age, prev, pulses;

    do_reset();

    // Idle after reset
    for (int c = 0; c < 5; c++) step('0);

    // All request; each holder releases after 3 granted cycles
    rv = '1; age = 0; prev = -1;
    for (int c = 0; c < 16; c++) begin
      if (m_holder >= 0 && age == 3) rv[m_holder] = 1'b0;
      step(rv);
      if (m_holder >= 0 && m_holder != prev) begin
        order.push_back(m_holder);
        age = 1;
      end else if (m_holder >= 0) begin
        age++;
      end
      prev = m_holder;
    end
    check("order_len", order.size(), 4);
    for (int i = 0; i < order.size() && i < 4; i++) check("order", order[i], i);

    // Rotation: after requester 2, search order is 3,0,1,2
    do_reset();
    step(4'b0100);
    step(4'b0000);
    step(4'b0101);
    check("rot_id", gnt_id, 0);
    check("rot_gnt", gnt, 4'b0001);

    // Asynchronous reset mid-grant
    do_reset();
    step(4'b0100);
    check("pre_rst_gnt", gnt, 4'b0100);
    #2 rst_n = 1'b0;
    #1;
    check("async_gnt", gnt, 0);
    check("async_valid", gnt_valid, 0);
    check("async_id", gnt_id, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step(4'b0110);
    check("post_rst_id", gnt_id, 1);

    // Long hold: contended then sole requester
    do_reset();
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      step(4'b1001);
      if (timeout) pulses++;
    end
    check("contend_pulses", pulses, TO_EN ? 1 : 0);
    check("contend_gnt", gnt, TO_EN ? 4'b1000 : 4'b0001);

    do_reset();
    pulses = 0;
    for (int c = 0; c < 100; c++) begin
      step(4'b0001);
      if (timeout) pulses++;
    end
    check("sole_pulses", pulses, TO_EN ? 19 : 0);
    check("sole_gnt", gnt, 4'b0001);

    // Randomized traffic
    do_reset();
    rv = '0;
    for (int c = 0; c < 400; c++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(3) == 0) rv[b] = ~rv[b];
      step(rv);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
